// File: rtl/loa_add_arbiter_pkg.sv
// loa_pkg: shared constants and helpers for the loa_adder_* family
package loa_pkg;
  localparam int LOA_WIDTH = 32;
  localparam int LOA_APX   = 8;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/loa_add_arbiter_if.sv
// loa_add_arbiter_if: requester bundle plus tagged response port
interface loa_add_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = loa_pkg::LOA_WIDTH);
  localparam int IDW = loa_pkg::idw(NREQ);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_apx;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;
  modport slave (input req_valid, req_a, req_b, req_cin, req_apx, rsp_ready,
                 output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id);
  modport master (output req_valid, req_a, req_b, req_cin, req_apx, rsp_ready,
                  input req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id);
endinterface

// File: rtl/loa_add_arbiter_adder.sv
// loa_adder_param: combinational lower-part-OR approximate adder with exact fallback
module loa_adder_param #(
  parameter int WIDTH = 32,
  parameter int APX   = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             apx,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] ex;
  assign ex = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  if (APX == 0) begin : g_exact
    assign {cout, sum} = ex;
  end else begin : g_loa
    // upper part is exact, seeded by the AND of the top approximate bits
    logic [WIDTH-APX:0] hi;
    assign hi = {1'b0, a[WIDTH-1:APX]} + {1'b0, b[WIDTH-1:APX]} + {{(WIDTH-APX){1'b0}}, a[APX-1] & b[APX-1]};
    assign {cout, sum} = apx ? {hi, a[APX-1:0] | b[APX-1:0]} : ex;
  end
endmodule

// File: rtl/loa_add_arbiter.sv
// loa_add_arbiter: round-robin sharing of one LOA adder with a 2-stage registered pipeline
module loa_add_arbiter
  import loa_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = LOA_WIDTH,
  parameter int APX   = LOA_APX
) (
  input logic clk,
  input logic rst,
  loa_add_arbiter_if.slave bus
);
  localparam int IDW = idw(NREQ);
  logic             s1_valid_q, s1_valid_d, s1_cin_q, s1_cin_d, s1_apx_q, s1_apx_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d, rr_ptr_q, rr_ptr_d, gnt_id;
  logic             rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d, sum;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             cout, gnt_found, xfer, s2_free, s1_adv, s1_free;
  loa_adder_param #(.WIDTH(WIDTH), .APX(APX)) u_add (
    .a(s1_a_q), .b(s1_b_q), .cin(s1_cin_q), .apx(s1_apx_q), .sum(sum), .cout(cout)
  );
  assign s2_free = !rsp_valid_q | bus.rsp_ready;
  assign s1_adv  = s1_valid_q & s2_free;
  assign s1_free = !s1_valid_q | s1_adv;
  assign xfer    = gnt_found & s1_free;
  assign bus.req_ready = xfer ? NREQ'(1) << gnt_id : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_id = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end
  // next state: capture on transfer, advance S1 into S2, drop response when consumed
  always_comb begin
    s1_valid_d  = xfer | (s1_valid_q & !s1_adv);
    s1_a_d      = xfer ? bus.req_a[gnt_id*WIDTH +: WIDTH] : s1_a_q;
    s1_b_d      = xfer ? bus.req_b[gnt_id*WIDTH +: WIDTH] : s1_b_q;
    s1_cin_d    = xfer ? bus.req_cin[gnt_id] : s1_cin_q;
    s1_apx_d    = xfer ? bus.req_apx[gnt_id] : s1_apx_q;
    s1_id_d     = xfer ? gnt_id : s1_id_q;
    rr_ptr_d    = xfer ? ((gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
    rsp_valid_d = s1_adv | (rsp_valid_q & !bus.rsp_ready);
    rsp_sum_d   = s1_adv ? sum : rsp_sum_q;
    rsp_cout_d  = s1_adv ? cout : rsp_cout_q;
    rsp_id_d    = s1_adv ? s1_id_q : rsp_id_q;
  end
  // state registers; reset drops any in-flight work
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cin_q    <= 1'b0;
      s1_apx_q    <= 1'b0;
      s1_id_q     <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_cin_q    <= s1_cin_d;
      s1_apx_q    <= s1_apx_d;
      s1_id_q     <= s1_id_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end
endmodule

// File: tb/tb_loa_add_arbiter.sv
// tb_loa_add_arbiter: directed checks of arithmetic, fairness, backpressure and reset
module tb_loa_add_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]  vld = '0;
  logic        rdy = 1'b1;
  logic [31:0] ta [4];
  logic [31:0] tb_b [4];
  logic [3:0]  tc = '0;
  logic [3:0]  tx = '0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  loa_add_arbiter_if #(.NREQ(4), .WIDTH(32)) ifc ();
  assign ifc.req_valid = vld;
  assign ifc.rsp_ready = rdy;
  assign ifc.req_cin   = tc;
  assign ifc.req_apx   = tx;
  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign ifc.req_a[i*32 +: 32] = ta[i];
    assign ifc.req_b[i*32 +: 32] = tb_b[i];
  end
  loa_add_arbiter #(.NREQ(4), .WIDTH(32), .APX(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic apx, input logic [31:0] es, input logic ec);
    @(negedge clk);
    ta[0] = a; tb_b[0] = b; tc[0] = cin; tx[0] = apx; vld = 4'b0001;
    #1 chk({tag, "_rdy"}, 64'(ifc.req_ready), 64'h1);
    @(negedge clk);
    vld = '0;
    #1 chk({tag, "_lat"}, 64'(ifc.rsp_valid), 64'h0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, 64'(ifc.rsp_valid), 64'h1);
    chk({tag, "_sum"}, 64'(ifc.rsp_sum), 64'(es));
    chk({tag, "_cout"}, 64'(ifc.rsp_cout), 64'(ec));
    chk({tag, "_id"}, 64'(ifc.rsp_id), 64'h0);
  endtask
  initial begin
    logic [31:0] hold_sum;
    logic [1:0]  hold_id;
    int xfers;
    for (int i = 0; i < 4; i++) begin ta[i] = '0; tb_b[i] = '0; end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", 64'(ifc.rsp_valid), 64'h0);
    chk("rst_sum", 64'(ifc.rsp_sum), 64'h0);
    chk("rst_cout", 64'(ifc.rsp_cout), 64'h0);
    chk("rst_id", 64'(ifc.rsp_id), 64'h0);
    chk("rst_rdy", 64'(ifc.req_ready), 64'h0);
    rst = 1'b0;
    single("apx_f0", 32'h000000F0, 32'h0000000F, 1'b0, 1'b1, 32'h000000FF, 1'b0);
    single("apx_80", 32'h00000080, 32'h00000080, 1'b0, 1'b1, 32'h00000180, 1'b0);
    single("exa_80", 32'h00000080, 32'h00000080, 1'b0, 1'b0, 32'h00000100, 1'b0);
    single("exa_ovf", 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1);
    single("apx_ovf", 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    // fairness from a fresh rr_ptr
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin ta[i] = 32'((i + 1) << 12); tb_b[i] = 32'(i); end
    tc = '0; tx = '0; rdy = 1'b1; vld = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 6) vld = '0;
      #1;
      if (k < 6) chk($sformatf("fair_rdy%0d", k), 64'(ifc.req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 2 && k < 8) begin
        chk($sformatf("fair_vld%0d", k), 64'(ifc.rsp_valid), 64'h1);
        chk($sformatf("fair_id%0d", k), 64'(ifc.rsp_id), 64'((k - 2) % 4));
        chk($sformatf("fair_sum%0d", k), 64'(ifc.rsp_sum), 64'(((k - 2) % 4 + 1) * 32'h1000 + (k - 2) % 4));
      end
      if (k == 8) chk("fair_idle", 64'(ifc.rsp_valid), 64'h0);
    end
    // backpressure on a stream from requester 2
    rdy = 1'b0; xfers = 0; tb_b[2] = 32'h1; tc[2] = 1'b0; tx[2] = 1'b0; vld = 4'b0100;
    hold_sum = '0; hold_id = '0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      ta[2] = 32'(32'h100 * (xfers + 1));
      #1;
      if (ifc.req_ready[2]) xfers++;
      if (k == 2) begin hold_sum = ifc.rsp_sum; hold_id = ifc.rsp_id; end
      if (k >= 3) begin
        chk($sformatf("bp_hold_vld%0d", k), 64'(ifc.rsp_valid), 64'h1);
        chk($sformatf("bp_hold_sum%0d", k), 64'(ifc.rsp_sum), 64'(hold_sum));
        chk($sformatf("bp_hold_id%0d", k), 64'(ifc.rsp_id), 64'(hold_id));
      end
    end
    chk("bp_xfers", 64'(xfers), 64'd2);
    chk("bp_rdy0", 64'(ifc.req_ready), 64'h0);
    chk("bp_first_sum", 64'(hold_sum), 64'h101);
    chk("bp_first_id", 64'(hold_id), 64'h2);
    @(negedge clk); vld = '0; rdy = 1'b1;
    #1 chk("bp_d1_sum", 64'(ifc.rsp_sum), 64'h101);
    @(negedge clk);
    #1;
    chk("bp_d2_vld", 64'(ifc.rsp_valid), 64'h1);
    chk("bp_d2_sum", 64'(ifc.rsp_sum), 64'h201);
    @(negedge clk);
    #1 chk("bp_d3_vld", 64'(ifc.rsp_valid), 64'h0);
    // reset with S1 and S2 both occupied
    for (int i = 0; i < 4; i++) begin ta[i] = 32'h5; tb_b[i] = 32'h6; end
    tc = '0; tx = '0; rdy = 1'b0; vld = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mr_full_vld", 64'(ifc.rsp_valid), 64'h1);
    chk("mr_full_rdy", 64'(ifc.req_ready), 64'h0);
    rst = 1'b1; vld = 4'b1111;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mr_vld", 64'(ifc.rsp_valid), 64'h0);
    chk("mr_rdy", 64'(ifc.req_ready), 64'h1);
    rdy = 1'b1;
    @(negedge clk); vld = '0;
    @(negedge clk);
    #1;
    chk("mr_rsp_id", 64'(ifc.rsp_id), 64'h0);
    chk("mr_rsp_sum", 64'(ifc.rsp_sum), 64'hB);
    // sparse grant: 1 then 3 then rr_ptr wraps to 0
    @(negedge clk);
    ta[1] = 32'h12345678; tb_b[1] = 32'h000000FF; tc[1] = 1'b1; tx[1] = 1'b1;
    ta[3] = 32'hFFFFFF80; tb_b[3] = 32'h00000080; tx[3] = 1'b1;
    ta[0] = 32'h7; tb_b[0] = 32'h9; tc[0] = 1'b1; tx[0] = 1'b1;
    vld = 4'b0010;
    #1 chk("sp_rdy1", 64'(ifc.req_ready), 64'b0010);
    @(negedge clk); vld = 4'b1000;
    #1 chk("sp_rdy3", 64'(ifc.req_ready), 64'b1000);
    @(negedge clk); vld = 4'b1001;
    #1;
    chk("sp_rdy0", 64'(ifc.req_ready), 64'b0001);
    chk("sp_id1", 64'(ifc.rsp_id), 64'h1);
    chk("sp_sum1", 64'({ifc.rsp_cout, ifc.rsp_sum}), 64'h0_123456FF);
    @(negedge clk); vld = '0;
    #1;
    chk("sp_id3", 64'(ifc.rsp_id), 64'h3);
    chk("sp_sum3", 64'({ifc.rsp_cout, ifc.rsp_sum}), 64'h1_00000080);
    @(negedge clk);
    #1;
    chk("sp_id0", 64'(ifc.rsp_id), 64'h0);
    chk("sp_sum0", 64'({ifc.rsp_cout, ifc.rsp_sum}), 64'h0_0000000F);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
